default_slave: RTL and testbench
================================

DEFAULT_SLAVE -- requirements
Module: default_slave

Interface
REQ-001 The block SHALL be synchronous to a single clock with an asynchronous, active-high reset.
REQ-002 Parameter: IDW, default 8 (`AXI_IDS_BITS), slave-side transaction ID width.
REQ-003 ACLK  input  1  clock; all state changes on rising edge.
REQ-004 ARESET  input  1  asynchronous active-high reset.
REQ-005 AWID  input  IDW  write address ID.
REQ-006 AWVALID  input  1  write address valid.
REQ-007 AWREADY  output  1  write address ready.
REQ-008 WLAST  input  1  last write beat.
REQ-009 WVALID  input  1  write data valid.
REQ-010 WREADY  output  1  write data ready.
REQ-011 BID  output  IDW  write response ID.
REQ-012 BRESP  output  2  write response code.
REQ-013 BVALID  output  1  write response valid.
REQ-014 BREADY  input  1  write response ready.
REQ-015 ARID  input  IDW  read address ID.
REQ-016 ARLEN  input  4  read burst length minus one.
REQ-017 ARVALID  input  1  read address valid.
REQ-018 ARREADY  output  1  read address ready.
REQ-019 RID  output  IDW  read data ID.
REQ-020 RDATA  output  32  read data.
REQ-021 RRESP  output  2  read response code.
REQ-022 RLAST  output  1  last read beat.
REQ-023 RVALID  output  1  read data valid.
REQ-024 RREADY  input  1  read data ready.

Function
REQ-025 The block SHALL terminate every transaction routed to the unmapped-address destination with DECERR (2'b11) on BRESP and RRESP.
REQ-026 Write FSM states: W_IDLE, W_DATA, W_RESP; read FSM states: R_IDLE, R_DATA; the two FSMs SHALL be fully independent and run concurrently.
REQ-027 W_IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID, capture AWID and go to W_DATA.
REQ-028 W_DATA: AWREADY=0, WREADY=1; beats are discarded; on WVALID&WLAST go to W_RESP; WVALID without WLAST stays in W_DATA.
REQ-029 W_RESP: BVALID=1, BID=captured AWID, BRESP=2'b11; hold stable until BREADY; on BVALID&BREADY return to W_IDLE.
REQ-030 Minimum write latency: AW handshake cycle N, earliest W handshake N+1, BVALID asserted cycle after WLAST handshake.
REQ-031 R_IDLE: ARREADY=1, RVALID=0; on ARVALID capture ARID and ARLEN, clear 4-bit beat counter, go to R_DATA.
REQ-032 R_DATA: ARREADY=0, RVALID=1, RID=captured ARID, RDATA=32'h0, RRESP=2'b11, RLAST=1 iff counter==captured ARLEN.
REQ-033 Counter SHALL increment only on RVALID&RREADY; on handshake with RLAST=1 return to R_IDLE; exactly ARLEN+1 beats (1..16) SHALL be issued.
REQ-034 ARLEN=4'hF SHALL produce 16 beats without counter wrap affecting RLAST; ARLEN=0 SHALL produce one beat with RLAST=1.
REQ-035 RVALID/RID/RLAST SHALL remain stable while RREADY=0 (backpressure on any beat).
REQ-036 New AW/AR SHALL NOT be accepted until the prior transaction on that channel completes (one outstanding per direction).
REQ-037 Outputs BID/BRESP/RID/RDATA/RRESP/RLAST SHALL be 0 when their VALID is 0.

Reset
REQ-038 On ARESET, both FSMs SHALL go to idle immediately, counter and captured ID/LEN to 0: AWREADY=1, ARREADY=1, all other outputs 0.
REQ-039 Reset mid-burst or mid-response SHALL abort the transaction with no further beats or response after release.

Verification
REQ-040 AWID=8'h25, 4-beat W with WLAST on beat 4, BREADY=1 -> single BVALID with BID=8'h25, BRESP=2'b11, one cycle.
REQ-041 ARID=8'h13, ARLEN=3, RREADY=1 -> 4 beats RDATA=0, RRESP=2'b11, RLAST only on beat 4, then ARREADY=1.
REQ-042 ARLEN=15, RREADY toggling 1/0 -> exactly 16 handshakes, outputs stable during RREADY=0, RLAST on 16th.
REQ-043 AW and AR same cycle, ARLEN=0 -> both accepted; RLAST on first beat; B and R complete independently.
REQ-044 ARESET asserted during beat 2 of ARLEN=7 -> RVALID=0 immediately, ARREADY=1, no beats after release.

Source files
------------

// File: rtl/default_slave.sv
// Default AXI slave: sinks any write or read routed to unmapped space
// and answers every transaction with DECERR on independent W and R FSMs.
module default_slave #(
  parameter int IDW = 8
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic [IDW-1:0] AWID,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  output logic [IDW-1:0] BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  input  logic [IDW-1:0] ARID,
  input  logic [3:0]     ARLEN,
  input  logic           ARVALID,
  output logic           ARREADY,
  output logic [IDW-1:0] RID,
  output logic [31:0]    RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY
);

  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  w_state_t       w_state;
  w_state_t       w_next;
  logic [IDW-1:0] aw_id_q;

  r_state_t       r_state;
  r_state_t       r_next;
  logic [IDW-1:0] ar_id_q;
  logic [3:0]     ar_len_q;
  logic [3:0]     beat_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_id_q <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && AWVALID)
        aw_id_q <= AWID;
    end
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID)
          w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST)
          w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BID    = aw_id_q;
        BRESP  = DECERR;
        if (BREADY)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // beat_q may wrap past ar_len_q on the final beat; RLAST only
  // matters while in R_DATA, which is left on that same handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_id_q  <= '0;
      ar_len_q <= '0;
      beat_q   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && ARVALID) begin
        ar_id_q  <= ARID;
        ar_len_q <= ARLEN;
        beat_q   <= '0;
      end else if (r_state == R_DATA && RREADY) begin
        beat_q <= beat_q + 4'd1;
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RID     = '0;
    RDATA   = '0;
    RRESP   = 2'b00;
    RLAST   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID)
          r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RID    = ar_id_q;
        RRESP  = DECERR;
        RLAST  = (beat_q == ar_len_q);
        if (RREADY && RLAST)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_default_slave.sv
// Scoreboard bench for default_slave: random AXI traffic, a
// transaction-level model of expected B/R responses, reset abort.
module tb_default_slave;

  localparam int IDW = 8;

  logic           ACLK = 1'b0;
  logic           ARESET;
  logic [IDW-1:0] AWID;
  logic           AWVALID;
  logic           AWREADY;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [IDW-1:0] ARID;
  logic [3:0]     ARLEN;
  logic           ARVALID;
  logic           ARREADY;
  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  default_slave #(.IDW(IDW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
  } rbeat_t;

  int total = 0;
  int bad   = 0;

  logic [IDW-1:0] wq[$];
  rbeat_t         rq[$];
  int w_phase = 0;
  int r_phase = 0;
  int b_cnt   = 0;
  int r_cnt   = 0;
  int b_mode  = 0;
  int r_mode  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a write is idle -> data -> resp, a read with length L
  // owes exactly L+1 DECERR beats; handshakes land on the next edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      chk("rst_awready", AWREADY, 1);
      chk("rst_arready", ARREADY, 1);
      chk("rst_others", {WREADY, BVALID, BID, BRESP, RVALID, RID,
                         RDATA, RRESP, RLAST}, 0);
      wq.delete();
      rq.delete();
      w_phase = 0;
      r_phase = 0;
    end else begin
      chk("awready", AWREADY, w_phase == 0);
      chk("wready", WREADY, w_phase == 1);
      chk("bvalid", BVALID, w_phase == 2);
      if (w_phase == 2 && wq.size() > 0)
        chk("b_payload", {BID, BRESP}, {wq[0], 2'b11});
      else
        chk("b_idle_zero", {BID, BRESP}, 0);
      chk("arready", ARREADY, r_phase == 0);
      chk("rvalid", RVALID, r_phase == 1);
      if (r_phase == 1 && rq.size() > 0)
        chk("r_payload", {RID, RDATA, RRESP, RLAST},
            {rq[0].id, 32'h0, 2'b11, rq[0].last});
      else
        chk("r_idle_zero", {RID, RDATA, RRESP, RLAST}, 0);

      if (w_phase == 0 && AWVALID) begin
        wq.push_back(AWID);
        w_phase = 1;
      end else if (w_phase == 1 && WVALID && WLAST) begin
        w_phase = 2;
      end else if (w_phase == 2 && BREADY) begin
        if (wq.size() > 0) void'(wq.pop_front());
        b_cnt++;
        w_phase = 0;
      end

      if (r_phase == 0 && ARVALID) begin
        for (int i = 0; i <= int'(ARLEN); i++)
          rq.push_back('{id: ARID, last: (i == int'(ARLEN))});
        r_phase = 1;
      end else if (r_phase == 1 && RREADY) begin
        rbeat_t b;
        r_cnt++;
        if (rq.size() > 0) begin
          b = rq.pop_front();
          if (b.last) r_phase = 0;
        end else begin
          chk("r_underflow", rq.size(), 1);
          r_phase = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      case (b_mode)
        0:       BREADY = 1'b1;
        1:       BREADY = 1'($urandom_range(0, 1));
        default: BREADY = ~BREADY;
      endcase
      case (r_mode)
        0:       RREADY = 1'b1;
        1:       RREADY = 1'($urandom_range(0, 1));
        default: RREADY = ~RREADY;
      endcase
    end
  end

  task automatic do_write(input logic [IDW-1:0] id, input int nb);
    bit ok;
    AWID = id;
    AWVALID = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge ACLK);
      if (AWREADY) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", ok, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    AWID = IDW'($urandom);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
      WVALID = 1'b1;
      WLAST = (b == nb - 1);
      ok = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge ACLK);
        if (WREADY) begin ok = 1; break; end
      end
      if (!ok) chk("w_timeout", ok, 1);
      @(posedge ACLK); #1;
      WVALID = 1'b0;
      WLAST = 1'b0;
    end
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [3:0] len);
    bit ok;
    ARID = id;
    ARLEN = len;
    ARVALID = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge ACLK);
      if (ARREADY) begin ok = 1; break; end
    end
    if (!ok) chk("ar_timeout", ok, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    ARID = IDW'($urandom);
    ARLEN = 4'($urandom);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge ACLK);
      if (w_phase == 0 && r_phase == 0) begin ok = 1; break; end
    end
    chk("drain", ok, 1);
    #1;
  endtask

  int b0, r0, exp_b, exp_r;

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWVALID = 1'b0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1;
    ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    b0 = b_cnt;
    do_write(8'h25, 4);
    drain();
    chk("aw25_one_b", b_cnt - b0, 1);

    r0 = r_cnt;
    do_read(8'h13, 4'd3);
    drain();
    chk("ar13_beats", r_cnt - r0, 4);

    r0 = r_cnt;
    r_mode = 2;
    do_read(8'h5a, 4'hF);
    drain();
    chk("len15_beats", r_cnt - r0, 16);
    r_mode = 0;

    b0 = b_cnt;
    r0 = r_cnt;
    fork
      do_write(8'h44, 1);
      do_read(8'h66, 4'd0);
    join
    drain();
    chk("same_cycle_b", b_cnt - b0, 1);
    chk("same_cycle_r", r_cnt - r0, 1);

    b0 = b_cnt;
    r0 = r_cnt;
    exp_b = 0;
    exp_r = 0;
    for (int t = 0; t < 30; t++) begin
      logic [3:0] len;
      int nb;
      len = 4'($urandom);
      nb = $urandom_range(1, 4);
      b_mode = $urandom_range(0, 2);
      r_mode = $urandom_range(0, 2);
      exp_b += 1;
      exp_r += int'(len) + 1;
      fork
        do_write(IDW'($urandom), nb);
        do_read(IDW'($urandom), len);
      join
    end
    b_mode = 1;
    r_mode = 1;
    drain();
    chk("rand_b_total", b_cnt - b0, exp_b);
    chk("rand_r_total", r_cnt - r0, exp_r);

    b_mode = 0;
    r_mode = 0;
    r0 = r_cnt;
    do_read(8'h7e, 4'd7);
    for (int k = 0; k < 50; k++) begin
      @(posedge ACLK);
      if (r_cnt == r0 + 1) break;
    end
    #2 ARESET = 1'b1;
    #1;
    chk("abort_rvalid", RVALID, 0);
    chk("abort_arready", ARREADY, 1);
    chk("abort_awready", AWREADY, 1);
    @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (20) @(posedge ACLK);
    chk("abort_beats", r_cnt - r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
